// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : opcodes and FSM encoding shared by the multiply/divide unit
// Rev 1.0
// ============================================================================
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// mdu_div_core : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;

  // quo_q starts as the dividend and is shifted out MSB-first as quotient bits enter
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    trial = {rem_q, quo_q[WIDTH-1]};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (trial >= {1'b0, dvs_q}) begin
      rem_d = WIDTH'(trial - {1'b0, dvs_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO
// Rev 1.0
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 div_signed, rs_neg, rt_neg, div_load;
  logic [WIDTH-1:0]     rs_mag, rt_mag, quo, rem;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod_w;

  assign div_signed = (op == MD_DIV);
  assign rs_neg     = div_signed & rs[WIDTH-1];
  assign rt_neg     = div_signed & rt[WIDTH-1];
  assign rs_mag     = rs_neg ? -rs : rs;
  assign rt_mag     = rt_neg ? -rt : rt;
  assign div_load   = (state_q == S_IDLE) && start && (op == MD_DIV || op == MD_DIVU);

  // Truncated 2W-bit product of the extended operands is exact for both signednesses
  assign a_ext  = (op == MD_MULT) ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
  assign b_ext  = (op == MD_MULT) ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
  assign prod_w = a_ext * b_ext;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (div_load),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MTHI: hi_d = rs;
            MD_MTLO: lo_d = rs;
            MD_MULT, MD_MULTU: begin
              prod_d  = prod_w;
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = S_MUL;
            end
            MD_DIV, MD_DIVU: begin
              qneg_d  = rs_neg ^ rt_neg;
              rneg_d  = rs_neg;
              dz_d    = (rt == '0);
              cnt_d   = CNT_W'(WIDTH - 1);
              busy_d  = 1'b1;
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        // Divide-by-zero quotient is forced to all-ones; the remainder path already yields rs
        lo_d    = dz_q ? '1 : (qneg_q ? -quo : quo);
        hi_d    = rneg_q ? -rem : rem;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// tb_mdu_iter : directed vectors plus a cycle-level reference model for mdu_iter
// Rev 1.0
// ============================================================================
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int MC = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  rs, rt;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi,lo} of one MUL/DIV operation
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    logic [31:0]        q, r;
    sa = a;
    sb = b;
    case (o)
      3'b000: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      3'b001: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          q = 32'hFFFF_FFFF; r = a;
        end else if (o == 3'b010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = 0;
        end else if (o == 3'b010) begin
          q = sa / sb; r = sa % sb;
        end else begin
          q = a / b; r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  // Expected outputs, advanced once per clock from the sampled inputs
  logic         e_busy = 0, e_done = 0;
  logic [31:0]  e_hi = 0, e_lo = 0;
  logic [63:0]  e_pend = 0;
  int           e_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_busy = 0; e_done = 0; e_hi = 0; e_lo = 0; e_left = 0;
    end else begin
      e_done = 0;
      if (e_busy) begin
        e_left = e_left - 1;
        if (e_left == 0) begin
          {e_hi, e_lo} = e_pend;
          e_busy = 0;
          e_done = 1;
        end
      end else if (start) begin
        case (op)
          3'b100: e_hi = rs;
          3'b101: e_lo = rs;
          3'b000, 3'b001: begin
            e_pend = ref_result(op, rs, rt); e_left = MC; e_busy = 1;
          end
          3'b010, 3'b011: begin
            e_pend = ref_result(op, rs, rt); e_left = W + 1; e_busy = 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if ({busy, done, hi, lo} !== {e_busy, e_done, e_hi, e_lo}) begin
        fails++;
        $display("FAIL cycle_model t=%0t act busy=%b done=%b hi=%h lo=%h exp busy=%b done=%b hi=%h lo=%h",
                 $time, busy, done, hi, lo, e_busy, e_done, e_hi, e_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom;
  endtask

  // Waits for busy to drop; returns the number of busy cycles seen
  task automatic wait_idle(output int ncyc);
    ncyc = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle timeout act busy=1 exp busy=0");
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(o, a, b);
    wait_idle(n);
    chk({name, "_cycles"}, n, exp_cyc);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_on  = 1'b1;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);

    run_op("mult_neg",  3'b000, 32'hFFFF_FFFE, 32'd3,         MC,    32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC,    32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",  3'b010, 32'hFFFF_FFF9, 32'd2,         W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2,         W + 1, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_7_m2",  3'b010, 32'd7,         32'hFFFF_FFFE, W + 1, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_min",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_z",    3'b011, 32'h0000_1234, 32'd0,         W + 1, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_z_neg", 3'b010, 32'hFFFF_FFF9, 32'd0,         W + 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    issue(3'b100, 32'hAAAA_0000, 32'd0);
    chk("mthi_hi", hi, 32'hAAAA_0000);
    chk("mthi_busy", {31'b0, busy}, 0);
    issue(3'b101, 32'h0000_5555, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_5555);
    chk("mtlo_done", {31'b0, done}, 0);
    issue(3'b110, 32'h1, 32'h1);
    chk("undef_busy", {31'b0, busy}, 0);

    // MTLO while a divide is running must be dropped
    issue(3'b011, 32'd100, 32'd7);
    issue(3'b101, 32'h0000_1111, 32'd0);
    chk("mtlo_busy_lo", lo, 32'h0000_5555);
    wait_idle(n);
    chk("div_after_mt_hi", hi, 32'd2);
    chk("div_after_mt_lo", lo, 32'd14);

    // Reset partway through a divide clears everything at once
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mult_6x7", 3'b000, 32'd6, 32'd7, MC, 32'd0, 32'd42);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
      if (i % 3 == 0) a[31] = 1'b1;
      issue(o, a, b);
      wait_idle(n);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
